// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares the single data-memory port between the pipeline MEM
//             stage (CPU) and a board-side debug/loader port. One access per
//             cycle. Round-robin on conflict. Registered request/ack on the
//             debug side. Saturating count of CPU stall cycles.
//  Ports    :
//    clk, reset              - clock, asynchronous active-low reset
//    cpu_req/we/addr/wdata   - MEM stage access request
//    cpu_rdata, cpu_stall    - load data / "not granted" to hazard logic
//    dbg_req/we/addr/wdata   - debug request, held stable until dbg_ack
//    dbg_ack, dbg_rdata      - registered completion and read data
//    mem_we/addr/wdata       - to dmem
//    mem_rdata               - from dmem (asynchronous read)
//    grant_dbg               - debug owns the port this cycle
//    conflict_clr            - synchronous clear of conflict_cnt
//    conflict_cnt            - saturating count of cpu_stall cycles
//  Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_stall,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [AW-1:0]    dbg_addr,
    input  logic [DW-1:0]    dbg_wdata,
    output logic             dbg_ack,
    output logic [DW-1:0]    dbg_rdata,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             grant_dbg,
    input  logic             conflict_clr,
    output logic [CNT_W-1:0] conflict_cnt
);

    // State records who owned the port in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t r_state;
    state_t w_next_state;
    logic   w_cpu_el;
    logic   w_dbg_el;
    logic   w_grant_cpu;
    logic   w_grant_dbg;

    // A request seen in its own ack cycle is the one just completed.
    assign w_cpu_el = cpu_req;
    assign w_dbg_el = dbg_req & ~dbg_ack;

    // ------------------------------------------------------------------
    // Grant and next-state. No grant is issued while reset is asserted,
    // so no write can reach dmem during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_cpu  = 1'b0;
        w_grant_dbg  = 1'b0;
        w_next_state = ST_IDLE;
        if (reset) begin
            if (w_cpu_el && w_dbg_el) begin
                // Alternate: debug wins only right after a CPU grant.
                if (r_state == ST_CPU) begin
                    w_grant_dbg = 1'b1;
                end else begin
                    w_grant_cpu = 1'b1;
                end
            end else begin
                w_grant_cpu = w_cpu_el;
                w_grant_dbg = w_dbg_el;
            end
        end
        if (w_grant_cpu) begin
            w_next_state = ST_CPU;
        end else if (w_grant_dbg) begin
            w_next_state = ST_DBG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux; idle port is driven to zero.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_grant_dbg) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~w_grant_cpu;
    assign grant_dbg = w_grant_dbg;

    // ------------------------------------------------------------------
    // Debug completion: ack one cycle after the grant, read data held
    // until the next debug grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= w_grant_dbg;
            if (w_grant_dbg) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: clear wins over increment, sticks at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (conflict_clr) begin
            conflict_cnt <= '0;
        end else if (cpu_stall && (conflict_cnt != C_CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Self-checking bench for dmem_port_arbiter. A 64-word memory
//             model serves the dmem port; a reference model tracks the
//             expected owner, ack, read data, memory contents and counters.
//             A second instance with CNT_W=4 shares the stimulus to exercise
//             counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        conflict_clr;
    logic [31:0] mem_rdata;

    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, dbg_ack, mem_we, grant_dbg;
    logic [15:0] conflict_cnt;

    logic [31:0] cpu_rdata4, dbg_rdata4, mem_addr4, mem_wdata4;
    logic        cpu_stall4, dbg_ack4, mem_we4, grant_dbg4;
    logic [3:0]  conflict_cnt4;

    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          last_owner;   // 0 none, 1 cpu, 2 debug
    bit          m_ack;
    logic [31:0] m_rdata;
    int          m_cnt;
    int          m_cnt4;

    dmem_port_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_dbg(grant_dbg), .conflict_clr(conflict_clr), .conflict_cnt(conflict_cnt)
    );

    dmem_port_arbiter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata4), .cpu_stall(cpu_stall4),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack4), .dbg_rdata(dbg_rdata4),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
        .grant_dbg(grant_dbg4), .conflict_clr(conflict_clr), .conflict_cnt(conflict_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: asynchronous read, write at the clock edge
    assign mem_rdata = env_mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then
    // advance the model at the edge. Returns 1ns after the rising edge.
    task automatic step();
        bit          el_c, el_d, g_c, g_d, stall, we_exp;
        logic [31:0] a_exp, d_exp;
        @(negedge clk);
        el_c = cpu_req;
        el_d = dbg_req && !m_ack;
        g_c  = 1'b0;
        g_d  = 1'b0;
        if (reset) begin
            if (el_c && el_d) begin
                // whoever did not own the port last time goes first
                if (last_owner == 1) g_d = 1'b1;
                else                 g_c = 1'b1;
            end else begin
                g_c = el_c;
                g_d = el_d;
            end
        end
        stall  = el_c && !g_c;
        we_exp = (g_c && cpu_we) || (g_d && dbg_we);
        a_exp  = g_c ? cpu_addr  : (g_d ? dbg_addr  : 32'h0);
        d_exp  = g_c ? cpu_wdata : (g_d ? dbg_wdata : 32'h0);

        check_eq("grant_dbg",    grant_dbg,    g_d);
        check_eq("cpu_stall",    cpu_stall,    stall);
        check_eq("mem_we",       mem_we,       we_exp);
        check_eq("mem_addr",     mem_addr,     a_exp);
        check_eq("mem_wdata",    mem_wdata,    d_exp);
        check_eq("dbg_ack",      dbg_ack,      m_ack);
        check_eq("dbg_rdata",    dbg_rdata,    m_rdata);
        check_eq("conflict_cnt", conflict_cnt, m_cnt);
        if (g_c && !cpu_we) check_eq("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[5:0]]);

        check_eq("cnt4",         conflict_cnt4, m_cnt4);
        check_eq("grant_dbg4",   grant_dbg4,    g_d);
        check_eq("cpu_stall4",   cpu_stall4,    stall);
        check_eq("mem_we4",      mem_we4,       we_exp);
        check_eq("mem_addr4",    mem_addr4,     a_exp);
        check_eq("mem_wdata4",   mem_wdata4,    d_exp);
        check_eq("dbg_ack4",     dbg_ack4,      m_ack);
        check_eq("dbg_rdata4",   dbg_rdata4,    m_rdata);
        check_eq("cpu_rdata4",   cpu_rdata4,    mem_rdata);

        if (!reset) begin
            last_owner = 0; m_ack = 0; m_rdata = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (conflict_clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (stall) begin
                if (m_cnt  < 65535) m_cnt++;
                if (m_cnt4 < 15)    m_cnt4++;
            end
            if (g_d) m_rdata = ref_mem[dbg_addr[5:0]];
            if (g_c && cpu_we) ref_mem[cpu_addr[5:0]] = cpu_wdata;
            if (g_d && dbg_we) ref_mem[dbg_addr[5:0]] = dbg_wdata;
            last_owner = g_c ? 1 : (g_d ? 2 : 0);
            m_ack      = g_d;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        last_owner = 0; m_ack = 0; m_rdata = 0; m_cnt = 0; m_cnt4 = 0;
        reset = 1'b0;
        conflict_clr = 1'b0;
        // CPU request during reset: stalled, nothing written
        set_cpu(1, 1, 32'h10, 32'h1111_1111);
        set_dbg(1, 1, 32'h20, 32'h2222_2222);
        step();
        step();
        reset = 1'b1;
        set_dbg(0, 0, 0, 0);

        // CPU alone: store 0xDEADBEEF to 0x10
        set_cpu(1, 1, 32'h10, 32'hDEAD_BEEF);
        step();
        set_cpu(0, 0, 0, 0);
        step();

        // Debug read alone, held through its ack cycle and once more
        set_dbg(1, 0, 32'h10, 32'h0);
        step();
        step();
        step();
        check_eq("dbg_rdata_beef", dbg_rdata, 32'hDEAD_BEEF);
        set_dbg(0, 0, 0, 0);
        step();

        // Continuous contention, debug writing
        for (int i = 0; i < 40; i++) begin
            set_cpu(1, i[0], 32'h30 + i, 32'hC000_0000 + i);
            set_dbg(1, 1, 32'h8 + (i % 4), 32'hD000_0000 + i);
            step();
        end
        check_eq("cnt4_saturated", conflict_cnt4, 4'd15);
        check_eq("cnt_twenty",     conflict_cnt,  16'd20);

        // Clear during a stall cycle (CPU just owned, debug not in ack)
        while (!(last_owner == 1 && !m_ack)) step();
        conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        check_eq("cnt_cleared", conflict_cnt, 16'd0);
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        step();

        // Build up a count, then reset in the debug ack cycle
        set_cpu(1, 1, 32'h5, 32'hABCD_0005);
        step();
        set_cpu(1, 0, 32'h6, 0);
        set_dbg(1, 0, 32'h5, 0);
        step();                 // debug granted, CPU stalled
        check_eq("pre_reset_ack", dbg_ack, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("rst_dbg_ack",   dbg_ack,      1'b0);
        check_eq("rst_dbg_rdata", dbg_rdata,    32'h0);
        check_eq("rst_cnt",       conflict_cnt, 16'd0);
        last_owner = 0; m_ack = 0; m_rdata = 0; m_cnt = 0; m_cnt4 = 0;
        step();
        reset = 1'b1;
        step();                 // CPU expected first after release
        step();
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);

        // Idle for 5 cycles, then contention must still start with CPU
        for (int i = 0; i < 5; i++) step();
        set_cpu(1, 0, 32'h1, 0);
        set_dbg(1, 0, 32'h2, 0);
        step();
        step();
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        step();

        // Randomized traffic; debug requester honours the hold-until-ack rule
        for (int i = 0; i < 400; i++) begin
            set_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom & 32'hFF, $urandom);
            if (!dbg_req || m_ack)
                set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                        $urandom & 32'hFF, $urandom);
            conflict_clr = ($urandom_range(0, 31) == 0);
            step();
        end
        conflict_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
